// File: rtl/pe_sched_pkg.sv
// Shared state type and default geometry for the PE row scheduler.
package pe_sched_pkg;
   localparam int WCOUNT   = 4;
   localparam int N_ROWS   = 64;
   localparam int N_COLS   = 64;
   localparam int PE_ACC_W = 14;

   typedef enum logic [2:0] {IDLE, CLR, MAC, FLUSH, OUT} sched_state_t;

   // Index width that stays legal for a single-entry range.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/pe_row_sched_if.sv
// Result channel of the PE row scheduler: one row dot product per valid/ready handshake.
interface pe_row_sched_if #(
   parameter int ROW_W = 6,
   parameter int ACC_W = 14
);
   logic             res_valid;
   logic             res_ready;
   logic [ACC_W-1:0] res_data;
   logic [ROW_W-1:0] res_row;

   modport master (output res_valid, res_data, res_row, input res_ready);
   modport slave  (input res_valid, res_data, res_row, output res_ready);
endinterface

// File: rtl/pe_sched_perf.sv
// Saturating job cycle counter, instantiated only when PE_SCHED_PERF_CNT_EN is defined.
module pe_sched_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        inc,
   output logic [31:0] cnt
);
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc && cnt != '1)
         cnt <= cnt + 32'd1;
   end
endmodule

// File: rtl/pe_row_sched.sv
// Row-by-row MAC scheduler for a single PE: clear, BEATS multiply beats, flush, hand off result.
// Optional cycle counter behind macro PE_SCHED_PERF_CNT_EN (cyc_cnt ties to 0 otherwise).
module pe_row_sched #(
   parameter int WCOUNT = pe_sched_pkg::WCOUNT,
   parameter int N_ROWS = pe_sched_pkg::N_ROWS,
   parameter int N_COLS = pe_sched_pkg::N_COLS
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                start,
   input  logic                                                abort,
   output logic                                                busy,
   output logic                                                done,
   output logic [pe_sched_pkg::idx_w(N_ROWS)-1:0]              row_idx,
   output logic [pe_sched_pkg::idx_w(N_COLS/WCOUNT)-1:0]       beat_idx,
   output logic                                                pe_en,
   output logic                                                pe_clr,
   output logic                                                pe_zero,
   input  logic [pe_sched_pkg::PE_ACC_W-1:0]                   pe_out,
   output logic [31:0]                                         cyc_cnt,
   pe_row_sched_if.master                                      res
);
   import pe_sched_pkg::*;

   localparam int BEATS = N_COLS / WCOUNT;
   localparam int RW    = idx_w(N_ROWS);
   localparam int BW    = idx_w(BEATS);
   localparam logic [RW-1:0] ROW_LAST  = RW'(N_ROWS - 1);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

   sched_state_t state;
   logic         res_vld;

   // PE is idle (en=0) during OUT, so pe_out is stable for the whole handshake.
   assign res.res_valid = res_vld;
   assign res.res_data  = res_vld ? pe_out : '0;
   assign res.res_row   = row_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         row_idx  <= '0;
         beat_idx <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         res_vld  <= 1'b0;
         pe_en    <= 1'b0;
         pe_zero  <= 1'b0;
         pe_clr   <= 1'b1;
      end else begin
         done    <= 1'b0;
         res_vld <= 1'b0;
         pe_en   <= 1'b0;
         pe_zero <= 1'b0;
         pe_clr  <= 1'b0;
         if (abort && state != IDLE) begin
            state    <= IDLE;
            busy     <= 1'b0;
            beat_idx <= '0;
            pe_clr   <= 1'b1;
         end else begin
            case (state)
               IDLE: if (start && !abort) begin
                  state    <= CLR;
                  busy     <= 1'b1;
                  row_idx  <= '0;
                  beat_idx <= '0;
                  pe_clr   <= 1'b1;
               end
               CLR: begin
                  state    <= MAC;
                  pe_en    <= 1'b1;
                  beat_idx <= '0;
               end
               MAC: begin
                  pe_en <= 1'b1;
                  if (beat_idx == BEAT_LAST) begin
                     state    <= FLUSH;
                     pe_zero  <= 1'b1;
                     beat_idx <= '0;
                  end else begin
                     beat_idx <= beat_idx + 1'b1;
                  end
               end
               FLUSH: begin
                  state   <= OUT;
                  res_vld <= 1'b1;
               end
               OUT: begin
                  if (res.res_ready) begin
                     if (row_idx == ROW_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state   <= CLR;
                        row_idx <= row_idx + 1'b1;
                        pe_clr  <= 1'b1;
                     end
                  end else begin
                     res_vld <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef PE_SCHED_PERF_CNT_EN
   logic start_acc;
   assign start_acc = (state == IDLE) && start && !abort;

   pe_sched_perf u_perf (
      .clk (clk),
      .rst (rst),
      .clr (start_acc),
      .inc (busy),
      .cnt (cyc_cnt)
   );
`else
   assign cyc_cnt = '0;
`endif
endmodule

// File: tb/tb_pe_row_sched.sv
// Bench for pe_row_sched: behavioural PE, per-row dot-product model, job table plus corner sequences.
module tb_pe_row_sched;
   import pe_sched_pkg::*;

   localparam int BEATS = N_COLS / WCOUNT;
   localparam int RW    = idx_w(N_ROWS);
   localparam int BW    = idx_w(BEATS);
   localparam int JOB   = N_ROWS * (BEATS + 3);

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
   logic busy, done, pe_en, pe_clr, pe_zero;
   logic [RW-1:0]       row_idx;
   logic [BW-1:0]       beat_idx;
   logic [PE_ACC_W-1:0] pe_out;
   logic [31:0]         cyc_cnt;

   pe_row_sched_if #(.ROW_W(RW), .ACC_W(PE_ACC_W)) res_if ();

   pe_row_sched dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .row_idx(row_idx), .beat_idx(beat_idx), .pe_en(pe_en), .pe_clr(pe_clr),
      .pe_zero(pe_zero), .pe_out(pe_out), .cyc_cnt(cyc_cnt), .res(res_if)
   );

   always #5 clk = ~clk;

   // Matrix M (rows x nibbles) and vector X.
   logic [3:0] mm [N_ROWS][N_COLS];
   logic [3:0] xv [N_COLS];

   function automatic int beat_sum(input int r, input int b);
      int s = 0;
      for (int w = 0; w < WCOUNT; w++)
         s += int'(mm[r][b*WCOUNT+w]) * int'(xv[b*WCOUNT+w]);
      return s;
   endfunction

   // Expected row result straight from the matrix definition.
   function automatic int ref_dot(input int r);
      int s = 0;
      for (int c = 0; c < N_COLS; c++) s += int'(mm[r][c]) * int'(xv[c]);
      return s;
   endfunction

   // PE: product register feeding an accumulator.
   logic [PE_ACC_W-1:0] pe_acc, pe_prod;
   always @(posedge clk) begin
      if (pe_clr) begin
         pe_acc  <= '0;
         pe_prod <= '0;
      end else if (pe_en) begin
         pe_acc  <= pe_acc + pe_prod;
         pe_prod <= pe_zero ? '0 : PE_ACC_W'(beat_sum(int'(row_idx), int'(beat_idx)));
      end
   end
   assign pe_out = pe_acc;

   int n_chk = 0, n_pass = 0;
   int cyc, exp_row, done_at, n_done;
   bit stalled_prev;
   logic [PE_ACC_W-1:0] prev_data;
   logic [RW-1:0]       prev_row;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic monitor();
      bit hs;
      hs = res_if.res_valid && res_if.res_ready && !rst && !abort;
      if (res_if.res_valid) chk("pe_en_in_out", 32'(pe_en), 0);
      if (stalled_prev) begin
         chk("stall_valid", 32'(res_if.res_valid), 1);
         chk("stall_data", 32'(res_if.res_data), 32'(prev_data));
         chk("stall_row", 32'(res_if.res_row), 32'(prev_row));
      end
      if (hs) begin
         chk("res_row", 32'(res_if.res_row), exp_row);
         chk("res_data", 32'(res_if.res_data), ref_dot(exp_row));
         exp_row++;
      end
      stalled_prev = res_if.res_valid && !res_if.res_ready && !rst && !abort;
      prev_data    = res_if.res_data;
      prev_row     = res_if.res_row;
      if (done === 1'b1) begin
         if (done_at < 0) done_at = cyc;
         n_done++;
      end
`ifndef PE_SCHED_PERF_CNT_EN
      chk("cyc_cnt_zero", cyc_cnt, 0);
`endif
   endtask

   // One clock: inputs set before the call, outputs observed mid-cycle.
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic fill(input int pat);
      for (int c = 0; c < N_COLS; c++)
         xv[c] = (pat == 0) ? 4'hF : (pat == 1) ? 4'h1 : 4'($urandom_range(0, 15));
      for (int r = 0; r < N_ROWS; r++)
         for (int c = 0; c < N_COLS; c++)
            mm[r][c] = (pat == 0) ? 4'hF : (pat == 1) ? 4'(r % 16) : 4'($urandom_range(0, 15));
   endtask

   task automatic run_job(input int stall_row, input int stall_len, input bit mid_start);
      int left;
      left = stall_len;
      exp_row = 0; done_at = -1; n_done = 0; stalled_prev = 0;
      res_if.res_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0; cyc = 0;
      for (int i = 0; i < 4*JOB && done_at < 0; i++) begin
         res_if.res_ready = 1'b1;
         if (left > 0 && res_if.res_valid && int'(row_idx) == stall_row) begin
            res_if.res_ready = 1'b0;
            left--;
         end
         start = mid_start && (i == 300);
         tick();
      end
      start = 1'b0;
      res_if.res_ready = 1'b1;
      chk("n_results", exp_row, N_ROWS);
   endtask

   typedef struct {
      int pat;
      int stall_row;
      int stall_len;
      bit mid_start;
      int exp_done;
      int exp_cnt;
   } vec_t;

   initial begin
      vec_t vt [5];
      bit   found, saw_vld;
      int   hold_cnt;

      vt[0] = '{0, -1, 0, 1'b0, JOB,     JOB};
      vt[1] = '{1, -1, 0, 1'b1, JOB,     JOB};
      vt[2] = '{0,  3, 5, 1'b0, JOB + 5, JOB + 5};
      vt[3] = '{2, -1, 0, 1'b0, JOB,     JOB};
      vt[4] = '{2,  7, 3, 1'b1, JOB + 3, JOB + 3};

      res_if.res_ready = 1'b1;
      exp_row = 0; done_at = -1; n_done = 0; stalled_prev = 0; cyc = 0;

      // Reset state
      rst = 1'b1; tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_row_idx", 32'(row_idx), 0);
      chk("rst_beat_idx", 32'(beat_idx), 0);
      chk("rst_res_valid", 32'(res_if.res_valid), 0);
      chk("rst_pe_en", 32'(pe_en), 0);
      chk("rst_pe_zero", 32'(pe_zero), 0);
      chk("rst_pe_clr", 32'(pe_clr), 1);
      chk("rst_res_data", 32'(res_if.res_data), 0);
      chk("rst_cyc_cnt", cyc_cnt, 0);
      rst = 1'b0; tick();
      chk("idle_pe_clr", 32'(pe_clr), 0);

      // start and abort together in IDLE: abort wins
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      chk("sa_busy0", 32'(busy), 0);
      tick();
      chk("sa_busy1", 32'(busy), 0);

      // Abort in MAC beat 7 of row 10
      fill(1);
      exp_row = 0; n_done = 0; stalled_prev = 0;
      start = 1'b1; tick(); start = 1'b0;
      found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         if (int'(row_idx) == 10 && int'(beat_idx) == 7 && pe_en && !pe_zero) found = 1;
         else tick();
      end
      chk("abort_reach", 32'(found), 1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_pe_clr", 32'(pe_clr), 1);
      chk("abort_res_valid", 32'(res_if.res_valid), 0);
      chk("abort_rows_before", exp_row, 10);
      saw_vld = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         saw_vld |= res_if.res_valid;
      end
      chk("abort_no_done", n_done, 0);
      chk("abort_no_valid", 32'(saw_vld), 0);
      run_job(-1, 0, 1'b0);
      chk("restart_done_cycle", done_at, JOB);

      // Reset while in OUT
      fill(0);
      exp_row = 0; n_done = 0; stalled_prev = 0;
      res_if.res_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (res_if.res_valid) found = 1;
         else tick();
      end
      chk("out_reach", 32'(found), 1);
      rst = 1'b1; tick();
      chk("orst_busy", 32'(busy), 0);
      chk("orst_done", 32'(done), 0);
      chk("orst_row_idx", 32'(row_idx), 0);
      chk("orst_beat_idx", 32'(beat_idx), 0);
      chk("orst_res_valid", 32'(res_if.res_valid), 0);
      chk("orst_pe_en", 32'(pe_en), 0);
      chk("orst_pe_zero", 32'(pe_zero), 0);
      chk("orst_pe_clr", 32'(pe_clr), 1);
      chk("orst_res_data", 32'(res_if.res_data), 0);
      chk("orst_cyc_cnt", cyc_cnt, 0);
      rst = 1'b0; res_if.res_ready = 1'b1;
      saw_vld = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         saw_vld |= res_if.res_valid | busy;
      end
      chk("orst_quiet", 32'(saw_vld), 0);
      chk("orst_no_done", n_done, 0);

      // Job table
      for (int v = 0; v < 5; v++) begin
         fill(vt[v].pat);
         run_job(vt[v].stall_row, vt[v].stall_len, vt[v].mid_start);
         chk($sformatf("v%0d_done_cycle", v), done_at, vt[v].exp_done);
         for (int i = 0; i < 3; i++) tick();
         chk($sformatf("v%0d_done_pulses", v), n_done, 1);
         chk($sformatf("v%0d_idle", v), 32'(busy), 0);
`ifdef PE_SCHED_PERF_CNT_EN
         hold_cnt = vt[v].exp_cnt;
`else
         hold_cnt = 0;
`endif
         chk($sformatf("v%0d_cyc_cnt", v), cyc_cnt, hold_cnt);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
